// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory bus arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU port, DMA port and memory-side signals of the arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_done;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_gnt, dma_done;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata, dma_gnt, dma_done, dma_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata, dma_gnt, dma_done, dma_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_latency_timer.sv
// arb_latency_timer: loadable down-counter flagging the final memory-latency cycle.
module arb_latency_timer import mem_arb_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serializes CPU/DMA accesses onto a fixed-latency shared memory.
// ARB_ROUND_ROBIN_EN enables round-robin tie-breaking; otherwise the CPU wins ties.
module mem_bus_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  state_t            state, state_nx;
  owner_t            owner, winner;
  logic              accept, capture, cnt_last, lat_we, sel_we;
  logic              cpu_gnt, dma_gnt, cpu_done, dma_done, mem_en, mem_we;
  logic [ADDR_W-1:0] sel_addr, mem_addr;
  logic [DATA_W-1:0] sel_wdata, mem_wdata, cpu_rdata, dma_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_owner <= OWN_DMA;
    else if (accept) last_owner <= winner;
  assign winner = bus.cpu_req && bus.dma_req ? (last_owner == OWN_CPU ? OWN_DMA : OWN_CPU)
                                             : (bus.cpu_req ? OWN_CPU : OWN_DMA);
`else
  assign winner = bus.cpu_req ? OWN_CPU : OWN_DMA;
`endif
  assign sel_we    = winner == OWN_CPU ? bus.cpu_we    : bus.dma_we;
  assign sel_addr  = winner == OWN_CPU ? bus.cpu_addr  : bus.dma_addr;
  assign sel_wdata = winner == OWN_CPU ? bus.cpu_wdata : bus.dma_wdata;
  always_comb begin
    accept   = state == IDLE && (bus.cpu_req || bus.dma_req);
    capture  = state == WAIT && cnt_last;
    state_nx = state == IDLE  ? (accept ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (capture ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  arb_latency_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ISSUE),
    .load_val (CNT_W'(MEM_LAT)),
    .last     (cnt_last)
  );
  // gnt/mem_en are set on the sampling edge so the ISSUE cycle sees them registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_gnt  <= accept && winner == OWN_CPU;
      dma_gnt  <= accept && winner == OWN_DMA;
      mem_en   <= accept;
      mem_we   <= accept && sel_we;
      cpu_done <= capture && owner == OWN_CPU;
      dma_done <= capture && owner == OWN_DMA;
      if (accept) begin
        owner     <= winner;
        lat_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (capture && !lat_we && owner == OWN_CPU) cpu_rdata <= bus.mem_rdata;
      if (capture && !lat_we && owner == OWN_DMA) dma_rdata <= bus.mem_rdata;
    end
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_done  = cpu_done;
  assign bus.dma_done  = dma_done;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.dma_rdata = dma_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, corner sequences, latency sweep and randomized model check.
module tb_mem_bus_arbiter;
  localparam int ML = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s15 ();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(ML)) dut (.clk(clk), .reset(reset), .bus(b));
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(s1));
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut15 (.clk(clk), .reset(reset), .bus(s15));

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int rd_wait = -1;
  logic [31:0] rd_val;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // memory environment: read data is only valid in the single cycle MEM_LAT after mem_en
  always @(negedge clk) begin
    if (rd_wait >= 0) rd_wait--;
    if (b.mem_en && b.mem_we) mem[b.mem_addr] = b.mem_wdata;
    if (b.mem_en && !b.mem_we) begin
      rd_wait = ML;
      rd_val = mem.exists(b.mem_addr) ? mem[b.mem_addr] : init_val(b.mem_addr);
    end
    b.mem_rdata = rd_wait == 0 ? rd_val : $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit dma;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit pre;
    logic [31:0] pdat;
    logic [31:0] ecr;
    logic [31:0] edr;
  } vec_t;
  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    int dc;
    @(posedge clk); #1;
    if (v.pre) mem[v.addr] = v.pdat;
    if (v.dma) begin
      b.dma_req = 1'b1; b.dma_we = v.we; b.dma_addr = v.addr; b.dma_wdata = v.wdata;
    end else begin
      b.cpu_req = 1'b1; b.cpu_we = v.we; b.cpu_addr = v.addr; b.cpu_wdata = v.wdata;
    end
    @(posedge clk); #1;
    chk("vec_gnt", {b.cpu_gnt, b.dma_gnt}, v.dma ? 2'b01 : 2'b10);
    chk("vec_mem_en_we", {b.mem_en, b.mem_we}, {1'b1, v.we});
    chk("vec_mem_addr", b.mem_addr, v.addr);
    chk("vec_mem_wdata", b.mem_wdata, v.wdata);
    b.cpu_req = 1'b0; b.dma_req = 1'b0;
    b.cpu_addr = $urandom; b.dma_addr = $urandom; b.cpu_wdata = $urandom; b.dma_wdata = $urandom;
    b.cpu_we = 1'($urandom); b.dma_we = 1'($urandom);
    dc = 0;
    for (int k = 2; k <= 40 && dc == 0; k++) begin
      @(posedge clk); #1;
      if (b.cpu_done || b.dma_done) begin
        dc = k;
        chk("vec_done_port", {b.cpu_done, b.dma_done}, v.dma ? 2'b01 : 2'b10);
      end
    end
    chk("vec_done_latency", dc, 2 + ML);
    chk("vec_rdata", {b.cpu_rdata, b.dma_rdata}, {v.ecr, v.edr});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = 0; b.cpu_wdata = 0;
    b.dma_req = 0; b.dma_we = 0; b.dma_addr = 0; b.dma_wdata = 0;
    s1.cpu_req = 0; s1.cpu_we = 0; s1.cpu_addr = 0; s1.cpu_wdata = 0;
    s1.dma_req = 0; s1.dma_we = 0; s1.dma_addr = 0; s1.dma_wdata = 0; s1.mem_rdata = 0;
    s15.cpu_req = 0; s15.cpu_we = 0; s15.cpu_addr = 0; s15.cpu_wdata = 0;
    s15.dma_req = 0; s15.dma_we = 0; s15.dma_addr = 0; s15.dma_wdata = 0; s15.mem_rdata = 0;
    tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
    tbl[3] = '{1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
    tbl[4] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        32'hCAFEF00D, 32'h12345678};
    tbl[5] = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b1, 32'h0BADF00D, 32'hCAFEF00D, 32'h0BADF00D};

    do_reset();
    @(posedge clk); #1;
    chk("reset_ctl", {b.cpu_gnt, b.dma_gnt, b.cpu_done, b.dma_done, b.mem_en, b.mem_we}, 6'b0);
    chk("reset_data", {b.mem_addr, b.mem_wdata}, 64'h0);
    chk("reset_rdata", {b.cpu_rdata, b.dma_rdata}, 64'h0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // both ports request continuously
    begin
      logic [1:0] gp [4];
      int gc [4];
      int ng;
      do_reset();
      @(posedge clk); #1;
      b.cpu_req = 1; b.cpu_we = 0; b.cpu_addr = 32'h04;
      b.dma_req = 1; b.dma_we = 0; b.dma_addr = 32'h08;
      ng = 0;
      for (int k = 1; k <= 60 && ng < 4; k++) begin
        @(posedge clk); #1;
        if (b.cpu_gnt || b.dma_gnt) begin
          gp[ng] = {b.cpu_gnt, b.dma_gnt};
          gc[ng] = k;
          ng++;
        end
      end
      b.cpu_req = 0; b.dma_req = 0;
      chk("tie_grant_count", ng, 4);
      for (int i = 0; i < ng; i++) chk("tie_owner", gp[i], (RR && i[0]) ? 2'b01 : 2'b10);
      for (int i = 1; i < ng; i++) chk("tie_spacing", gc[i] - gc[i-1], ML + 3);
      repeat (10) @(posedge clk);
    end

    // DMA request raised while the CPU access is in flight
    begin
      int dg, cd;
      @(posedge clk); #1;
      b.cpu_req = 1; b.cpu_we = 0; b.cpu_addr = 32'h0C;
      dg = 0; cd = 0;
      for (int k = 1; k <= 30 && dg == 0; k++) begin
        @(posedge clk); #1;
        if (k == 1) b.cpu_req = 0;
        if (k == 3) begin b.dma_req = 1; b.dma_we = 0; b.dma_addr = 32'h14; end
        if (b.cpu_done && cd == 0) cd = k;
        if (b.dma_gnt) begin dg = k; b.dma_req = 0; end
      end
      chk("inflight_cpu_done", cd, ML + 2);
      chk("inflight_dma_gnt", dg, ML + 4);
      repeat (10) @(posedge clk);
    end

    // asynchronous reset during WAIT
    begin
      logic seen;
      vec_t v;
      @(posedge clk); #1;
      b.cpu_req = 1; b.cpu_we = 0; b.cpu_addr = 32'h20; b.cpu_wdata = 32'h77;
      @(posedge clk); #1;
      b.cpu_req = 0;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("abort_ctl", {b.cpu_gnt, b.dma_gnt, b.cpu_done, b.dma_done, b.mem_en, b.mem_we}, 6'b0);
      chk("abort_mem", {b.mem_addr, b.mem_wdata}, 64'h0);
      chk("abort_rdata", {b.cpu_rdata, b.dma_rdata}, 64'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      seen = 1'b0;
      repeat (ML + 6) begin
        @(posedge clk); #1;
        seen |= b.cpu_done | b.dma_done;
      end
      chk("abort_no_done", seen, 1'b0);
      v = '{1'b0, 1'b0, 32'h24, 32'h0, 1'b1, 32'h600DCAFE, 32'h600DCAFE, 32'h0};
      run_vec(v);
    end

    // latency sweep MEM_LAT = 1 and 15
    begin
      int d1, d15;
      @(posedge clk); #1;
      s1.cpu_req = 1; s1.cpu_addr = 32'h30;
      s15.cpu_req = 1; s15.cpu_addr = 32'h34;
      d1 = 0; d15 = 0;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clk); #1;
        s1.mem_rdata = k == 2 ? 32'h1111_0001 : $urandom;
        s15.mem_rdata = k == 16 ? 32'h1515_0015 : $urandom;
        if (k == 1) begin
          chk("sweep_gnt", {s1.cpu_gnt, s1.mem_en, s15.cpu_gnt, s15.mem_en}, 4'hF);
          s1.cpu_req = 0; s15.cpu_req = 0;
        end
        if (s1.cpu_done && d1 == 0) d1 = k;
        if (s15.cpu_done && d15 == 0) d15 = k;
      end
      chk("sweep_done_lat1", d1, 3);
      chk("sweep_done_lat15", d15, 17);
      chk("sweep_rdata1", s1.cpu_rdata, 32'h1111_0001);
      chk("sweep_rdata15", s15.cpu_rdata, 32'h1515_0015);
    end

    // randomized traffic against a transaction-level reference
    begin
      int t0, nf;
      bit t_own, t_we, last;
      logic [31:0] t_addr, t_wdata, t_data, ea, ew, ecr, edr;
      mem.delete();
      ref_mem.delete();
      do_reset();
      t0 = -100; nf = 0; last = 1'b1; t_own = 0; t_we = 0;
      t_addr = 0; t_wdata = 0; t_data = 0; ea = 0; ew = 0; ecr = 0; edr = 0;
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk); #1;
        if (c == t0 + 1) begin ea = t_addr; ew = t_wdata; end
        if (c == t0 + 2 + ML && !t_we) begin
          if (t_own) edr = t_data;
          else ecr = t_data;
        end
        chk("rnd_gnt", {b.cpu_gnt, b.dma_gnt}, c == t0 + 1 ? (t_own ? 2'b01 : 2'b10) : 2'b00);
        chk("rnd_mem_en_we", {b.mem_en, b.mem_we}, {c == t0 + 1, c == t0 + 1 && t_we});
        chk("rnd_mem_addr", b.mem_addr, ea);
        chk("rnd_mem_wdata", b.mem_wdata, ew);
        chk("rnd_done", {b.cpu_done, b.dma_done}, c == t0 + 2 + ML ? (t_own ? 2'b01 : 2'b10) : 2'b00);
        chk("rnd_rdata", {b.cpu_rdata, b.dma_rdata}, {ecr, edr});
        if (!b.cpu_req || b.cpu_gnt) begin
          b.cpu_we = 1'($urandom); b.cpu_addr = {26'h0, 4'($urandom), 2'b00}; b.cpu_wdata = $urandom;
        end
        if (!b.dma_req || b.dma_gnt) begin
          b.dma_we = 1'($urandom); b.dma_addr = {26'h0, 4'($urandom), 2'b00}; b.dma_wdata = $urandom;
        end
        b.cpu_req = b.cpu_req ? (b.cpu_gnt ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) != 0)
                              : $urandom_range(0, 3) == 0;
        b.dma_req = b.dma_req ? (b.dma_gnt ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) != 0)
                              : $urandom_range(0, 3) == 0;
        if (c >= nf && (b.cpu_req || b.dma_req)) begin
          t_own = b.cpu_req && b.dma_req ? (RR ? !last : 1'b0) : !b.cpu_req;
          last = t_own;
          t0 = c;
          nf = c + 3 + ML;
          t_we = t_own ? b.dma_we : b.cpu_we;
          t_addr = t_own ? b.dma_addr : b.cpu_addr;
          t_wdata = t_own ? b.dma_wdata : b.cpu_wdata;
          if (t_we) ref_mem[t_addr] = t_wdata;
          else t_data = ref_mem.exists(t_addr) ? ref_mem[t_addr] : init_val(t_addr);
        end
      end
      b.cpu_req = 0; b.dma_req = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer for the single shared instruction/data memory of the multi-cycle CPU. It shares that memory between the CPU memory port and a DMA/boot-loader port. It serializes accesses, drives the memory's fixed-latency interface, and returns read data with a one-cycle completion pulse. It sits between the CPU's IorD/MemRead/MemWrite path and the memory array.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles after the mem_en cycle; legal range 1..15

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  one-cycle pulse: request accepted, inputs latched
- cpu_done  out  1  one-cycle pulse: access complete
- cpu_rdata  out  DATA_W  read data, valid while cpu_done=1 and held after
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: same as cpu_* for the DMA port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Owner register: CPU or DMA.
- IDLE
  - Sample cpu_req and dma_req.
  - If either is high, select a winner, latch its we/addr/wdata and set owner.
  - Go to ISSUE.
  - If neither is high, stay in IDLE.
- ISSUE (1 cycle)
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request.
  - The owner's gnt=1.
  - Load the latency counter with MEM_LAT and go to WAIT.
- WAIT
  - Decrement the counter each cycle; mem_en=0.
  - When the counter reaches 1, capture mem_rdata into the owner's rdata register on that edge (reads only) and go to DONE.
- DONE (1 cycle)
  - The owner's done=1, then return to IDLE.
- Writes run the same sequence; the rdata registers are unchanged on writes.
- The non-owner's gnt, done and rdata are untouched throughout.
- Requests arriving while not in IDLE are not acknowledged. They are re-evaluated at the next IDLE.
- A request withdrawn before gnt is simply dropped. A req still high in IDLE after done counts as a new request.
- The latched request is immune to requester input changes after gnt.

## Timing
- Reset values: state=IDLE, all gnt/done/mem_en/mem_we = 0, mem_addr/mem_wdata/rdata = 0, last_owner=DMA.
- Reset mid-access aborts the access immediately: no done is issued and memory outputs drop to 0 asynchronously.
- req sampled at edge E0 → gnt and mem_en in cycle 1 → mem_rdata valid in cycle 1+MEM_LAT → done in cycle 2+MEM_LAT.
- Minimum spacing between successive gnts is MEM_LAT+3 cycles (the IDLE cycle is mandatory).
- All outputs are registered; no combinational path exists from any input to any output.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: on simultaneous requests, grant the port that is not last_owner. last_owner updates at every grant.
  - Undefined: fixed priority, CPU always wins ties; last_owner register is removed.
  - Single-requester behaviour is identical either way.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - owner encoding (OWN_CPU=0, OWN_DMA=1)
  - latency counter width constant (4 bits)
- One sub-module, arb_latency_timer: loadable down-counter with a `last` flag. The FSM, latches and rdata registers stay in the top level.

## Test plan
- Single CPU read, MEM_LAT=2, memory returns 0xDEADBEEF → cpu_gnt in cycle 1, cpu_done in cycle 4 with cpu_rdata=0xDEADBEEF; dma_* stay 0.
- DMA write addr=0x40, wdata=0x12345678 → exactly one mem_en cycle with mem_we=1 and matching addr/data; dma_done 3 cycles later; dma_rdata unchanged.
- Both req held continuously, round-robin defined → grants alternate CPU, DMA, CPU, DMA. Macro undefined → all grants go to CPU.
- DMA req raised during a CPU WAIT → DMA granted in the cycle after the IDLE that follows cpu_done, never earlier.
- Reset asserted during WAIT → all outputs 0 immediately, no done pulse; after release, a new CPU read completes normally.
- MEM_LAT=1 and MEM_LAT=15 sweep → done arrives exactly MEM_LAT+2 cycles after the request-sampling edge.
